// File: rtl/apb4_archinfo_if.sv
// APB4 bus bundle for the architecture-info slave.
// Signal names keep the slave-side _i/_o suffixes so waveforms match the block's port list.
interface apb4_archinfo_if #(
   parameter int ADDR_WIDTH = 12
);
   logic [ADDR_WIDTH-1:0] paddr_i;
   logic [2:0]            pprot_i;
   logic                  psel_i;
   logic                  penable_i;
   logic                  pwrite_i;
   logic [3:0]            pstrb_i;
   logic [31:0]           pwdata_i;
   logic                  pready_o;
   logic [31:0]           prdata_o;
   logic                  pslverr_o;

   modport master (
      output paddr_i, pprot_i, psel_i, penable_i, pwrite_i, pstrb_i, pwdata_i,
      input  pready_o, prdata_o, pslverr_o
   );

   modport slave (
      input  paddr_i, pprot_i, psel_i, penable_i, pwrite_i, pstrb_i, pwdata_i,
      output pready_o, prdata_o, pslverr_o
   );
endinterface

// File: rtl/apb4_archinfo_mc.sv
// APB4 architecture-info slave: ID/CAP registers, lockable USER scratch bank and a
// 64-bit uptime counter whose high word is latched into a shadow on every UPT_LO read.
module apb4_archinfo_mc #(
   parameter int          ADDR_WIDTH = 12,
   parameter int          NUM_USER   = 4,
   parameter int          WAIT_CYC   = 0,
   parameter logic [31:0] SYS_ID     = 32'hFFFF_2022,
   parameter logic [31:0] IDL_VAL    = 32'hF123_4567,
   parameter logic [31:0] IDH_VAL    = 32'h0000_0001,
   parameter logic [31:0] USER_RST   = 32'h0
) (
   input  logic           clk_i,
   input  logic           rst_i,
   apb4_archinfo_if.slave bus
);
   localparam int UIW = (NUM_USER > 1) ? $clog2(NUM_USER) : 1;
   localparam int WW  = ADDR_WIDTH - 2;
   localparam logic [WW-1:0] W_CTRL   = WW'(0);
   localparam logic [WW-1:0] W_SYS    = WW'(1);
   localparam logic [WW-1:0] W_IDL    = WW'(2);
   localparam logic [WW-1:0] W_IDH    = WW'(3);
   localparam logic [WW-1:0] W_UPT_LO = WW'(4);
   localparam logic [WW-1:0] W_UPT_HI = WW'(5);
   localparam logic [WW-1:0] W_CAP    = WW'(6);
   localparam logic [WW-1:0] W_USER   = WW'(8);

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

   state_t        state_q, state_d;
   logic [2:0]    wcnt_q, wcnt_d;
   logic          lock_q, cnt_en_q;
   logic [31:0]   user_q [NUM_USER];
   logic [63:0]   upt_q;
   logic [31:0]   shadow_q;

   logic [WW-1:0]  widx, uoff;
   logic [UIW-1:0] uidx;
   logic           hit, ro, ctrl_sel, user_sel, uptlo_sel;
   logic [31:0]    rd_val;
   logic           xfer_done, err, commit;
   logic           unused_bits;

   assign widx        = bus.paddr_i[ADDR_WIDTH-1:2];
   assign uoff        = widx - W_USER;
   assign uidx        = uoff[UIW-1:0];
   assign unused_bits = ^{bus.pprot_i, bus.paddr_i[1:0]};

   always_comb begin
      rd_val    = '0;
      hit       = 1'b1;
      ro        = 1'b1;
      ctrl_sel  = 1'b0;
      user_sel  = 1'b0;
      uptlo_sel = 1'b0;
      case (widx)
         W_CTRL: begin
            rd_val   = {30'd0, cnt_en_q, lock_q};
            ro       = 1'b0;
            ctrl_sel = 1'b1;
         end
         W_SYS:    rd_val = SYS_ID;
         W_IDL:    rd_val = IDL_VAL;
         W_IDH:    rd_val = IDH_VAL;
         W_UPT_LO: begin
            rd_val    = upt_q[31:0];
            uptlo_sel = 1'b1;
         end
         W_UPT_HI: rd_val = shadow_q;
         W_CAP:    rd_val = {15'd0, lock_q, 5'd0, 3'(WAIT_CYC), 3'd0, 5'(NUM_USER)};
         default: begin
            if ((widx >= W_USER) && (uoff < WW'(NUM_USER))) begin
               rd_val   = user_q[uidx];
               ro       = 1'b0;
               user_sel = 1'b1;
            end else begin
               hit = 1'b0;
            end
         end
      endcase
   end

   // LOCK is judged here, in the completing cycle, not at setup.
   assign err       = !hit || (bus.pwrite_i && ro) ||
                      (bus.pwrite_i && lock_q && (ctrl_sel || user_sel));
   assign xfer_done = (state_q == S_RESP) && bus.psel_i && bus.penable_i && !rst_i;
   assign commit    = xfer_done && !err;

   assign bus.pready_o  = xfer_done;
   assign bus.pslverr_o = xfer_done && err;
   assign bus.prdata_o  = (xfer_done && !err && !bus.pwrite_i) ? rd_val : 32'd0;

   always_comb begin
      state_d = state_q;
      wcnt_d  = wcnt_q;
      case (state_q)
         S_IDLE: begin
            if (bus.psel_i && !bus.penable_i) begin
               if (WAIT_CYC == 0) begin
                  state_d = S_RESP;
               end else begin
                  state_d = S_WAIT;
                  wcnt_d  = 3'(WAIT_CYC - 1);
               end
            end
         end
         S_WAIT: begin
            if (!bus.psel_i)                         state_d = S_IDLE;
            else if (wcnt_q != 3'd0)                 wcnt_d  = wcnt_q - 3'd1;
            else if (bus.penable_i)                  state_d = S_RESP;
         end
         S_RESP:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q  <= S_IDLE;
         wcnt_q   <= '0;
         lock_q   <= 1'b0;
         cnt_en_q <= 1'b0;
         upt_q    <= '0;
         shadow_q <= '0;
         for (int k = 0; k < NUM_USER; k++) user_q[k] <= USER_RST;
      end else begin
         state_q <= state_d;
         wcnt_q  <= wcnt_d;
         if (cnt_en_q) upt_q <= upt_q + 64'd1;
         if (commit && !bus.pwrite_i && uptlo_sel) shadow_q <= upt_q[63:32];
         if (commit && bus.pwrite_i) begin
            // LOCK is sticky: a 0 written to bit0 leaves it set.
            if (ctrl_sel && bus.pstrb_i[0]) begin
               lock_q   <= lock_q | bus.pwdata_i[0];
               cnt_en_q <= bus.pwdata_i[1];
            end
            for (int k = 0; k < NUM_USER; k++) begin
               if (user_sel && (uidx == UIW'(k))) begin
                  for (int b = 0; b < 4; b++) begin
                     if (bus.pstrb_i[b]) user_q[k][8*b +: 8] <= bus.pwdata_i[8*b +: 8];
                  end
               end
            end
         end
      end
   end
endmodule
